// File: rtl/fp_norm_pkg.sv
// Shared sizing functions and flag bundle for the floating-point normaliser pipeline.
// Sizes are derived from the format width so callers only choose FPWID.
package fp_norm_pkg;

    function automatic int f_emsb(input int fpwid);
        case (fpwid)
            64:      return 10;
            128:     return 14;
            default: return 7;
        endcase
    endfunction

    function automatic int f_fmsb(input int fpwid);
        case (fpwid)
            64:      return 51;
            128:     return 111;
            default: return 22;
        endcase
    endfunction

    function automatic int f_fx(input int fpwid);
        return 2 * f_fmsb(fpwid) + 3;
    endfunction

    typedef struct packed {
        logic special;
        logic inexact;
        logic under;
        logic over;
    } flags_t;

endpackage

// File: rtl/fp_lzc_reg.sv
// Registered leading-zero counter; one ce-qualified clock of latency, no back-pressure.
// An all-zero input counts as W.
module fp_lzc_reg #(
    parameter int  W  = 28,
    localparam int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [W-1:0]  d_i,
    output logic [LW-1:0] lzc_o
);

    logic [LW-1:0] lzc_d;
    logic [LW-1:0] lzc_q;

    // Scanning upward lets the highest set bit have the last word.
    always_comb begin
        lzc_d = LW'(W);
        for (int i = 0; i < W; i++) begin
            if (d_i[i]) lzc_d = LW'(W - 1 - i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)     lzc_q <= '0;
        else if (ce) lzc_q <= lzc_d;
    end

    assign lzc_o = lzc_q;

endmodule

// File: rtl/fp_normalize_pipe.sv
// Normalises the three-whole-digit intermediate into {hidden, fraction, guard, round, sticky} plus flags.
// Fixed latency of 4 ce-qualified clocks, one operation per ce cycle, no back-pressure.
module fp_normalize_pipe
    import fp_norm_pkg::*;
#(
    parameter int  FPWID = 32,
    parameter int  TAGW  = 8,
    localparam int EMSB  = f_emsb(FPWID),
    localparam int FMSB  = f_fmsb(FPWID),
    localparam int FX    = f_fx(FPWID)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            valid_i,
    input  logic [TAGW-1:0] tag_i,
    input  logic            sign_i,
    input  logic [EMSB:0]   exp_i,
    input  logic [FX:0]     sig_i,
    input  logic            under_i,
    output logic            valid_o,
    output logic [TAGW-1:0] tag_o,
    output logic            sign_o,
    output logic [EMSB:0]   exp_o,
    output logic [FMSB+5:0] sig_o,
    output logic            inexact_o,
    output logic            under_o,
    output logic            over_o
);

    localparam int EW  = EMSB + 1;
    localparam int XW  = EMSB + 2;
    localparam int MW  = FMSB + 6;
    localparam int LO  = FMSB - 2;
    localparam int LZW = $clog2(MW + 1);

    typedef struct packed {
        logic            vld;
        logic [TAGW-1:0] tag;
        logic            sign;
        logic [XW-1:0]   exp;
        logic [MW-1:0]   mant;
        flags_t          flg;
    } pay_t;

    // ---------------- stage 1: capture and classify ----------------
    logic            s1_vld_q, s1_sign_q, s1_under_q, s1_spec_q, s1_spec_d;
    logic [TAGW-1:0] s1_tag_q;
    logic [EW-1:0]   s1_exp_q;
    logic [FX:0]     s1_sig_q;
    logic [1:0]      s1_inc_q, s1_inc_d;

    always_comb begin
        s1_spec_d = (exp_i == {EW{1'b1}}) && !under_i;
        s1_inc_d  = 2'd0;
        if (!s1_spec_d) begin
            if (sig_i[FX])        s1_inc_d = 2'd2;
            else if (sig_i[FX-1]) s1_inc_d = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_tag_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_sig_q   <= '0;
            s1_under_q <= 1'b0;
            s1_spec_q  <= 1'b0;
            s1_inc_q   <= 2'd0;
        end else if (ce) begin
            s1_vld_q   <= valid_i;
            s1_tag_q   <= tag_i;
            s1_sign_q  <= sign_i;
            s1_exp_q   <= exp_i;
            s1_sig_q   <= sig_i;
            s1_under_q <= under_i;
            s1_spec_q  <= s1_spec_d;
            s1_inc_q   <= s1_inc_d;
        end
    end

    // ---------------- stage 2: exponent adjust, overflow, alignment ----------------
    pay_t          s2_d, s2_q;
    logic [XW-1:0] exp_ext, exp_sum;

    always_comb begin
        s2_d             = '0;
        s2_d.vld         = s1_vld_q;
        s2_d.tag         = s1_tag_q;
        s2_d.sign        = s1_sign_q;
        s2_d.flg.special = s1_spec_q;
        s2_d.flg.under   = s1_under_q;
        exp_ext = s1_under_q ? {s1_exp_q[EMSB], s1_exp_q} : {1'b0, s1_exp_q};
        exp_sum = exp_ext + XW'(s1_inc_q);
        s2_d.exp = exp_sum;
        // Bottom working bit collects everything below the kept field.
        case (s1_inc_q)
            2'd2: begin
                s2_d.mant        = {s1_sig_q[FX -: MW-1], |s1_sig_q[LO:0]};
                s2_d.flg.inexact = |s1_sig_q[LO:0];
            end
            2'd1: begin
                s2_d.mant        = {s1_sig_q[FX-1 -: MW-1], |s1_sig_q[LO-1:0]};
                s2_d.flg.inexact = |s1_sig_q[LO-1:0];
            end
            default: begin
                s2_d.mant        = {s1_sig_q[FX-2 -: MW-1], |s1_sig_q[LO-2:0]};
                s2_d.flg.inexact = |s1_sig_q[LO-2:0];
            end
        endcase
        if (!s1_spec_q && !s1_under_q && (exp_sum >= XW'({EW{1'b1}}))) begin
            s2_d.exp         = XW'({EW{1'b1}});
            s2_d.mant        = '0;
            s2_d.flg.over    = 1'b1;
            s2_d.flg.inexact = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)     s2_q <= '0;
        else if (ce) s2_q <= s2_d;
    end

    // ---------------- stage 3: leading-zero count and right-shift amount ----------------
    pay_t           s3_q;
    logic [LZW-1:0] lzc_q;
    logic [LZW-1:0] rsh_d, s3_rsh_q;
    logic [XW-1:0]  neg_exp;

    fp_lzc_reg #(.W(MW)) u_lzc (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .d_i   (s2_q.mant),
        .lzc_o (lzc_q)
    );

    always_comb begin
        neg_exp = -s2_q.exp;
        rsh_d   = '0;
        if (s2_q.exp[XW-1]) begin
            if (neg_exp > XW'(MW)) rsh_d = LZW'(MW);
            else                   rsh_d = neg_exp[LZW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_q     <= '0;
            s3_rsh_q <= '0;
        end else if (ce) begin
            s3_q     <= s2_q;
            s3_rsh_q <= rsh_d;
        end
    end

    // ---------------- stage 4: shift and select result ----------------
    logic [LZW-1:0]  lsh;
    logic [MW-1:0]   mant_l, mant_r, lost_mask;
    logic [EW-1:0]   exp_l;
    logic            lost;
    logic            vld_d, sign_d, inexact_d, under_d, over_d;
    logic [TAGW-1:0] tag_d;
    logic [EW-1:0]   exp_d;
    logic [MW-1:0]   sig_d;
    logic            vld_q, sign_q, inexact_q, under_q, over_q;
    logic [TAGW-1:0] tag_q;
    logic [EW-1:0]   exp_q;
    logic [MW-1:0]   sig_q;

    always_comb begin
        // Exponent is the floor for the left shift, so small exponents produce denormals.
        lsh       = (s3_q.exp < XW'(lzc_q)) ? s3_q.exp[LZW-1:0] : lzc_q;
        mant_l    = s3_q.mant << lsh;
        exp_l     = s3_q.exp[EMSB:0] - EW'(lsh);
        lost_mask = ~({MW{1'b1}} << s3_rsh_q);
        lost      = |(s3_q.mant & lost_mask);
        mant_r    = (s3_q.mant >> s3_rsh_q) | MW'(lost);

        vld_d     = s3_q.vld;
        tag_d     = s3_q.tag;
        sign_d    = s3_q.sign;
        inexact_d = s3_q.flg.inexact;
        under_d   = 1'b0;
        over_d    = 1'b0;
        exp_d     = '0;
        sig_d     = '0;
        if (s3_q.flg.over) begin
            exp_d  = {EW{1'b1}};
            over_d = 1'b1;
        end else if (s3_q.flg.special) begin
            exp_d = {EW{1'b1}};
            sig_d = s3_q.mant;
        end else if (s3_q.mant == '0) begin
            inexact_d = 1'b0;
            under_d   = s3_q.flg.under;
        end else if (s3_q.flg.under) begin
            sig_d     = mant_r;
            under_d   = 1'b1;
            inexact_d = s3_q.flg.inexact | lost;
        end else begin
            sig_d = mant_l;
            exp_d = exp_l;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= 1'b0;
            tag_q     <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            sig_q     <= '0;
            inexact_q <= 1'b0;
            under_q   <= 1'b0;
            over_q    <= 1'b0;
        end else if (ce) begin
            vld_q     <= vld_d;
            tag_q     <= tag_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            sig_q     <= sig_d;
            inexact_q <= inexact_d;
            under_q   <= under_d;
            over_q    <= over_d;
        end
    end

    assign valid_o   = vld_q;
    assign tag_o     = tag_q;
    assign sign_o    = sign_q;
    assign exp_o     = exp_q;
    assign sig_o     = sig_q;
    assign inexact_o = inexact_q;
    assign under_o   = under_q;
    assign over_o    = over_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed bench for fp_normalize_pipe at FPWID=32 with hand-computed expectations.
module tb_fp_normalize_pipe;

    logic        clk = 1'b0;
    logic        rst, ce, valid_i, sign_i, under_i;
    logic [7:0]  tag_i, exp_i;
    logic [47:0] sig_i;
    logic        valid_o, sign_o, inexact_o, under_o, over_o;
    logic [7:0]  tag_o, exp_o;
    logic [27:0] sig_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_normalize_pipe #(.FPWID(32), .TAGW(8)) dut (
        .clk(clk), .rst(rst), .ce(ce), .valid_i(valid_i), .tag_i(tag_i),
        .sign_i(sign_i), .exp_i(exp_i), .sig_i(sig_i), .under_i(under_i),
        .valid_o(valid_o), .tag_o(tag_o), .sign_o(sign_o), .exp_o(exp_o),
        .sig_o(sig_o), .inexact_o(inexact_o), .under_o(under_o), .over_o(over_o)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one operation with ce held high and leave its result on the outputs.
    task automatic run_one(input logic [7:0] e, input logic [47:0] s, input logic u,
                           input logic sg, input logic [7:0] t);
        ce = 1'b1; valid_i = 1'b1; exp_i = e; sig_i = s; under_i = u; sign_i = sg; tag_i = t;
        step;
        valid_i = 1'b0; exp_i = '0; sig_i = '0; under_i = 1'b0; sign_i = 1'b0; tag_i = '0;
        step; step; step;
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b0; valid_i = 1'b0; tag_i = '0; sign_i = 1'b0;
        exp_i = '0; sig_i = '0; under_i = 1'b0;
        step; step;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_o); end
        tests++; if ({tag_o, exp_o, sig_o} !== 44'h0) begin fails++; $display("FAIL reset_data got %h want 0", {tag_o, exp_o, sig_o}); end
        tests++; if ({sign_o, inexact_o, under_o, over_o} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", {sign_o, inexact_o, under_o, over_o}); end
        rst = 1'b0;
    endtask

    task automatic test_one;
        run_one(8'd127, 48'd1 << 45, 1'b0, 1'b0, 8'h11);
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL one_valid got %b want 1", valid_o); end
        tests++; if (tag_o !== 8'h11) begin fails++; $display("FAIL one_tag got %h want 11", tag_o); end
        tests++; if (exp_o !== 8'd127) begin fails++; $display("FAIL one_exp got %0d want 127", exp_o); end
        tests++; if (sig_o !== 28'h8000000) begin fails++; $display("FAIL one_sig got %h want 8000000", sig_o); end
        tests++; if ({inexact_o, under_o, over_o} !== 3'b000) begin fails++; $display("FAIL one_flags got %b want 000", {inexact_o, under_o, over_o}); end
    endtask

    task automatic test_carry;
        run_one(8'd127, (48'd1 << 46) | 48'd1, 1'b0, 1'b1, 8'h12);
        tests++; if (exp_o !== 8'd128) begin fails++; $display("FAIL carry_exp got %0d want 128", exp_o); end
        tests++; if (sig_o !== 28'h8000001) begin fails++; $display("FAIL carry_sig got %h want 8000001", sig_o); end
        tests++; if ({sign_o, inexact_o, under_o, over_o} !== 4'b1100) begin fails++; $display("FAIL carry_flags got %b want 1100", {sign_o, inexact_o, under_o, over_o}); end
    endtask

    task automatic test_left_norm;
        run_one(8'd10, 48'd1 << 43, 1'b0, 1'b0, 8'h13);
        tests++; if (exp_o !== 8'd8) begin fails++; $display("FAIL lnorm_exp got %0d want 8", exp_o); end
        tests++; if (sig_o !== 28'h8000000) begin fails++; $display("FAIL lnorm_sig got %h want 8000000", sig_o); end
        run_one(8'd3, 48'd1 << 20, 1'b0, 1'b0, 8'h14);
        tests++; if (exp_o !== 8'd0) begin fails++; $display("FAIL denorm_exp got %0d want 0", exp_o); end
        tests++; if (sig_o !== 28'h0000020) begin fails++; $display("FAIL denorm_sig got %h want 0000020", sig_o); end
        tests++; if ({inexact_o, under_o, over_o} !== 3'b000) begin fails++; $display("FAIL denorm_flags got %b want 000", {inexact_o, under_o, over_o}); end
    endtask

    task automatic test_underflow;
        run_one(8'hFC, (48'd1 << 45) | (48'd1 << 22), 1'b1, 1'b0, 8'h15);
        tests++; if (exp_o !== 8'd0) begin fails++; $display("FAIL under_exp got %h want 00", exp_o); end
        tests++; if (sig_o !== 28'h0800001) begin fails++; $display("FAIL under_sig got %h want 0800001", sig_o); end
        tests++; if ({inexact_o, under_o, over_o} !== 3'b010) begin fails++; $display("FAIL under_flags got %b want 010", {inexact_o, under_o, over_o}); end
        run_one(8'hFC, (48'd1 << 45) | (48'd1 << 20), 1'b1, 1'b0, 8'h16);
        tests++; if (sig_o !== 28'h0800001) begin fails++; $display("FAIL under_drop_sig got %h want 0800001", sig_o); end
        tests++; if ({inexact_o, under_o} !== 2'b11) begin fails++; $display("FAIL under_drop_flags got %b want 11", {inexact_o, under_o}); end
        run_one(8'h80, 48'd1 << 45, 1'b1, 1'b0, 8'h17);
        tests++; if (sig_o !== 28'h0000001) begin fails++; $display("FAIL under_sat_sig got %h want 0000001", sig_o); end
        tests++; if ({exp_o, inexact_o, under_o} !== 10'b0000000011) begin fails++; $display("FAIL under_sat_flags got %b want 0000000011", {exp_o, inexact_o, under_o}); end
    endtask

    task automatic test_overflow;
        run_one(8'hFE, 48'd1 << 47, 1'b0, 1'b0, 8'h18);
        tests++; if (exp_o !== 8'hFF) begin fails++; $display("FAIL ovf_exp got %h want FF", exp_o); end
        tests++; if (sig_o !== 28'h0) begin fails++; $display("FAIL ovf_sig got %h want 0", sig_o); end
        tests++; if ({inexact_o, under_o, over_o} !== 3'b101) begin fails++; $display("FAIL ovf_flags got %b want 101", {inexact_o, under_o, over_o}); end
        run_one(8'hFE, 48'd1 << 46, 1'b0, 1'b0, 8'h19);
        tests++; if ({exp_o, over_o} !== 9'h1FF) begin fails++; $display("FAIL ovf_edge got %h want 1FF", {exp_o, over_o}); end
        run_one(8'hFF, (48'd1 << 45) | (48'd1 << 30), 1'b0, 1'b0, 8'h1A);
        tests++; if (exp_o !== 8'hFF) begin fails++; $display("FAIL nan_exp got %h want FF", exp_o); end
        tests++; if (sig_o !== 28'h8001000) begin fails++; $display("FAIL nan_sig got %h want 8001000", sig_o); end
        tests++; if ({inexact_o, under_o, over_o} !== 3'b000) begin fails++; $display("FAIL nan_flags got %b want 000", {inexact_o, under_o, over_o}); end
    endtask

    task automatic test_zero;
        run_one(8'd50, 48'h0, 1'b0, 1'b1, 8'h1B);
        tests++; if ({exp_o, sig_o} !== 36'h0) begin fails++; $display("FAIL zero_data got %h want 0", {exp_o, sig_o}); end
        tests++; if ({sign_o, inexact_o, over_o} !== 3'b100) begin fails++; $display("FAIL zero_flags got %b want 100", {sign_o, inexact_o, over_o}); end
    endtask

    // ce alternates 1,0,1,0...; junk valid ops offered on ce-low cycles must be ignored.
    task automatic test_back_to_back;
        int n;
        logic       want_v;
        logic [7:0] want_t, want_e;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            ce = (c % 2 == 0);
            sig_i = 48'd1 << 45; under_i = 1'b0; sign_i = 1'b0;
            if (!ce) begin
                valid_i = 1'b1; tag_i = 8'hEE; exp_i = 8'd5;
            end else if (n < 3) begin
                valid_i = 1'b1; tag_i = 8'hA0 + 8'(n); exp_i = 8'd100 + 8'(n);
            end else begin
                valid_i = 1'b0; tag_i = 8'h00; exp_i = 8'd0;
            end
            step;
            if (ce) n++;
            want_v = (n >= 4) && (n <= 6);
            want_t = 8'hA0 + 8'(n - 4);
            want_e = 8'd100 + 8'(n - 4);
            tests++; if (valid_o !== want_v) begin fails++; $display("FAIL b2b_valid cyc %0d got %b want %b", c, valid_o, want_v); end
            if (want_v) begin
                tests++; if (tag_o !== want_t) begin fails++; $display("FAIL b2b_tag cyc %0d got %h want %h", c, tag_o, want_t); end
                tests++; if (exp_o !== want_e) begin fails++; $display("FAIL b2b_exp cyc %0d got %0d want %0d", c, exp_o, want_e); end
            end
        end
        valid_i = 1'b0; ce = 1'b1;
    endtask

    task automatic test_reset_midstream;
        ce = 1'b1; sig_i = 48'd1 << 45; under_i = 1'b0; sign_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid_i = 1'b1; tag_i = 8'hC0 + 8'(k); exp_i = 8'd60;
            step;
        end
        valid_i = 1'b0; rst = 1'b1;
        step;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", valid_o); end
        tests++; if ({tag_o, sign_o, exp_o, sig_o} !== 45'h0) begin fails++; $display("FAIL rstmid_data got %h want 0", {tag_o, sign_o, exp_o, sig_o}); end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step;
            tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_stale cyc %0d got %b want 0", k, valid_o); end
        end
    endtask

    initial begin
        test_reset;
        test_one;
        test_carry;
        test_left_norm;
        test_underflow;
        test_overflow;
        test_zero;
        test_back_to_back;
        test_reset_midstream;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
